minimig_spi_host: RTL

Byte-wide SPI mode-0 master. It is the initiator end of the Minimig host-controller SPI link, which Minimig terminates as a responder through its chip selects, SPI data in, SPI data out and SPI clock. It lets an on-chip controller (soft CPU or test sequencer) drive Minimig's SPI chip selects and the SD-card select directly, replacing the external MCU. The block sits in the clk_28 domain and feeds the same SPI pins Minimig samples.

---
 rtl/minimig_spi_pkg.sv | 9 +
 rtl/minimig_spi_host_timer.sv | 45 ++++
 rtl/minimig_spi_host.sv | 81 ++++++++
 3 files changed

// File: rtl/minimig_spi_pkg.sv
// Shared types and constants for the Minimig host-side SPI master.
package minimig_spi_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} spi_state_e;

  localparam int SPI_BYTE_W       = 8;
  localparam int CS_W_DEFAULT     = 4;
  localparam int CS_SD            = 0;
  localparam int CS_MINIMIG_FIRST = 1;
endpackage

// File: rtl/minimig_spi_host_timer.sv
// SCK generator for the SPI master: half-period divider plus 3-bit bit counter.
module spi_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic sck,
  output logic sample_en,
  output logic shift_en,
  output logic last_bit
);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic       div_tc;

  assign div_tc    = (div_cnt == DIV_LAST);
  assign last_bit  = (bit_cnt == 3'd7);
  // Sampling and shifting share the last cycle of each high phase.
  assign sample_en = active && sck && div_tc;
  assign shift_en  = sample_en && !last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
    end else if (start) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
    end else if (active) begin
      if (div_tc) begin
        div_cnt <= '0;
        sck     <= ~sck;
        if (sck) bit_cnt <= bit_cnt + 3'd1;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/minimig_spi_host.sv
// Byte-wide SPI mode-0 master driving Minimig's host SPI link and SD-card select.
module minimig_spi_host
  import minimig_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_W    = CS_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_wr,
  input  logic [CS_W-1:0]       cs_n_in,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  rx_valid,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  busy,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic [CS_W-1:0]       scs_n
);
  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_SHIFT = SHIFT;

  logic [0:0]            state;
  logic [SPI_BYTE_W-1:0] shreg;
  logic                  accept;
  logic                  sample_en;
  logic                  shift_en;
  logic                  last_bit;

  assign tx_ready = (state == ST_IDLE);
  assign busy     = (state == ST_SHIFT);
  assign accept   = tx_valid && tx_ready;

  spi_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .active    (busy),
    .sck       (sck),
    .sample_en (sample_en),
    .shift_en  (shift_en),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      sdo      <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        state <= ST_SHIFT;
        shreg <= tx_data;
        sdo   <= tx_data[SPI_BYTE_W-1];
      end else if (shift_en) begin
        shreg <= {shreg[SPI_BYTE_W-2:0], sdi};
        sdo   <= shreg[SPI_BYTE_W-2];
      end else if (sample_en && last_bit) begin
        state    <= ST_IDLE;
        rx_data  <= {shreg[SPI_BYTE_W-2:0], sdi};
        rx_valid <= 1'b1;
        sdo      <= 1'b1;
      end
    end
  end

  // Selects only move while idle so a transfer never sees a select edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scs_n <= '1;
    end else if (cs_wr && tx_ready && !accept) begin
      scs_n <= cs_n_in;
    end
  end
endmodule
